dkong_bus_hold: RTL and testbench
=================================

# dkong_bus_hold

Bus-hold responder for the sprite DMA path: it receives the DMA engine's hold request and turns it into a CPU bus request. It waits for the CPU's bus acknowledge, then grants hold to the DMA and switches work-RAM ownership to it. When the request drops, it hands the bus back with a programmable turnaround. It sits between the sprite DMA engine and the Z80 core's BUSRQ/BUSAK pins, and drives the RAM address/data mux select.

## Interface
- RELEASE_DLY, 2, clock-enabled cycles the bus stays on the DMA side after HLDA falls; legal range 0..15
- WDOG_LIMIT, 16'h1000, maximum enabled cycles a single grant may last; only used with watchdog compiled in
- I_CLK  in  1  system clock; the single clock of the block
- I_RST  in  1  reset, asynchronous, active-high
- I_CLK_EN  in  1  clock enable; all state and counter updates occur only on enabled edges
- I_HRQ  in  1  hold request from the DMA engine; level, held high for the whole transfer
- I_BUSAKn  in  1  CPU bus acknowledge, active-low, same clock domain, no synchronizer
- O_BUSRQn  out  1  CPU bus request, active-low
- O_HLDA  out  1  hold acknowledge to the DMA engine
- O_BUS_SEL  out  1  RAM bus owner select: 1 = DMA, 0 = CPU
- O_BUSY  out  1  high in any state other than IDLE
- O_HOLD_CNT  out  16  duration of the last completed grant, in enabled cycles, saturating
- O_WDOG  out  1  sticky flag: a grant was forcibly ended by the watchdog

## Operation
- Reset values:
  - O_BUSRQn = 1, O_HLDA = 0, O_BUS_SEL = 0, O_BUSY = 0, O_HOLD_CNT = 0, O_WDOG = 0.
  - State = IDLE; the re-arm flag is cleared.
- IDLE:
  - I_HRQ = 1 and re-armed → O_BUSRQn <= 0, go to REQ.
- REQ:
  - I_HRQ = 0 (abort) → O_BUSRQn <= 1, go to WAITREL.
  - Otherwise, I_BUSAKn = 0 → O_HLDA <= 1, O_BUS_SEL <= 1, grant counter <= 0, go to GRANT.
  - Abort takes priority when both occur in the same cycle.
- GRANT:
  - Each enabled cycle: grant counter increments, saturating at 16'hFFFF.
  - I_HRQ = 0 → O_HLDA <= 0, O_HOLD_CNT <= grant counter, turn counter <= RELEASE_DLY, go to TURN.
  - If I_BUSAKn rises during GRANT (CPU protocol violation), continue holding. Exit happens only through I_HRQ or the watchdog.
- TURN:
  - Turn counter = 0 → O_BUS_SEL <= 0, O_BUSRQn <= 1, go to WAITREL.
  - Otherwise, decrement the turn counter.
  - With RELEASE_DLY = 0, TURN lasts exactly one enabled cycle.
- WAITREL:
  - I_BUSAKn = 1 → go to IDLE.
- Re-arm rule: after a normal release, the block is re-armed immediately. After a watchdog release, it is re-armed only once I_HRQ has been sampled low.
- O_BUSY is registered and equals (next state != IDLE).

## Timing
- I_HRQ rise → O_BUSRQn low: 1 enabled cycle.
- I_BUSAKn low (in REQ) → O_HLDA and O_BUS_SEL high: 1 enabled cycle.
- I_HRQ fall (in GRANT) → O_HLDA low: 1 enabled cycle.
- O_HLDA fall → O_BUS_SEL low and O_BUSRQn high: RELEASE_DLY+1 enabled cycles.
- O_BUS_SEL never falls before O_HLDA. O_HLDA is never high while O_BUS_SEL is low.
- Enabled cycles with I_CLK_EN = 0 are frozen: no counter or state advance.
- Asserting I_RST mid-grant immediately returns all outputs to their reset values.

## Configuration
- DKONG_BUS_HOLD_WDOG_EN defined:
  - In GRANT, when the grant counter reaches WDOG_LIMIT-1, treat it as an I_HRQ fall: O_HLDA <= 0, latch O_HOLD_CNT, go to TURN.
  - Set O_WDOG and clear the re-arm flag.
  - O_WDOG clears only on I_RST.
- DKONG_BUS_HOLD_WDOG_EN undefined:
  - No grant limit; O_WDOG is tied 0.
  - The re-arm flag is always set; WDOG_LIMIT is ignored.

## Structure
- Shared package dkong_pkg holds:
  - the state enum (IDLE, REQ, GRANT, TURN, WAITREL);
  - HOLD_CNT_W = 16 and TURN_CNT_W = 4.
- The block needs no sub-module; a single FSM with its counters is sufficient.

## Test plan
- Normal grant, RELEASE_DLY = 2, I_CLK_EN = 1, CPU acks 3 cycles after BUSRQn falls, I_HRQ held 1536 cycles:
  - O_BUSRQn falls 1 cycle after I_HRQ rises; O_HLDA rises 1 cycle after I_BUSAKn falls.
  - O_BUS_SEL falls 3 cycles after O_HLDA falls.
  - O_HOLD_CNT holds the number of enabled GRANT cycles, reported exactly.
- Abort in REQ, with I_HRQ falling before the CPU acks:
  - O_HLDA never rises and O_BUSRQn returns to 1.
  - The block returns to IDLE only after I_BUSAKn is high.
- I_CLK_EN toggling at 1/4 rate: all latencies scale to enabled cycles only, and O_HOLD_CNT counts enabled cycles only.
- Watchdog, with macro defined and WDOG_LIMIT = 16, I_HRQ held high:
  - O_HLDA drops after 16 GRANT cycles, O_WDOG = 1, and there is no new O_BUSRQn fall until I_HRQ toggles low then high.
- Without the macro, the same stimulus as the watchdog case: O_HLDA stays high for all 100 cycles and O_WDOG stays 0.
- I_RST asserted during GRANT: O_HLDA, O_BUS_SEL and O_BUSY are 0 and O_BUSRQn is 1 immediately, with no clock edge required.

Source files
------------

// File: rtl/dkong_pkg.sv
// Shared state encoding and counter widths for the sprite-DMA bus-hold responder.
package dkong_pkg;

    localparam int unsigned HOLD_CNT_W = 16;
    localparam int unsigned TURN_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        TURN,
        WAITREL
    } state_t;

endpackage

// File: rtl/dkong_bus_hold.sv
// Bus-hold responder: turns the sprite DMA hold request into a Z80 BUSRQ/BUSAK handshake.
// Optional grant watchdog compiled in with DKONG_BUS_HOLD_WDOG_EN.
module dkong_bus_hold
    import dkong_pkg::*;
#(
    parameter int unsigned            RELEASE_DLY = 2,
    parameter logic [HOLD_CNT_W-1:0]  WDOG_LIMIT  = 16'h1000
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_CLK_EN,
    input  logic                  I_HRQ,
    input  logic                  I_BUSAKn,
    output logic                  O_BUSRQn,
    output logic                  O_HLDA,
    output logic                  O_BUS_SEL,
    output logic                  O_BUSY,
    output logic [HOLD_CNT_W-1:0] O_HOLD_CNT,
    output logic                  O_WDOG
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [HOLD_CNT_W-1:0]   r_gcnt;
    logic [HOLD_CNT_W-1:0]   w_gcnt_nxt;
    logic [HOLD_CNT_W-1:0]   w_gcnt_inc;
    logic [TURN_CNT_W-1:0]   r_tcnt;
    logic [TURN_CNT_W-1:0]   w_tcnt_nxt;
    logic [HOLD_CNT_W-1:0]   w_hold_cnt_nxt;
    logic                    w_busrq_n_nxt;
    logic                    w_hlda_nxt;
    logic                    w_bus_sel_nxt;
    logic                    r_armed;
    logic                    w_armed;
    logic                    w_wdog_hit;
    logic                    w_wdog_fire;
    logic                    w_release;

`ifdef DKONG_BUS_HOLD_WDOG_EN
    localparam bit WDOG_EN = 1'b1;

    // Sticky record that a grant was cut short; cleared only by reset.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            O_WDOG <= 1'b0;
        end else if (I_CLK_EN && w_wdog_fire) begin
            O_WDOG <= 1'b1;
        end
    end
`else
    localparam bit WDOG_EN = 1'b0;

    assign O_WDOG = 1'b0;
`endif

    assign w_gcnt_inc  = (r_gcnt == '1) ? r_gcnt : r_gcnt + HOLD_CNT_W'(1);
    assign w_wdog_hit  = WDOG_EN && (r_gcnt == WDOG_LIMIT - HOLD_CNT_W'(1));
    assign w_wdog_fire = (r_state == GRANT) && I_HRQ && w_wdog_hit;
    assign w_release   = !I_HRQ || w_wdog_hit;
    assign w_armed     = r_armed || !WDOG_EN;

    // After a watchdog cut the DMA must drop HRQ once before it may ask again.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_armed <= 1'b0;
        end else if (I_CLK_EN) begin
            if (w_wdog_fire) begin
                r_armed <= 1'b0;
            end else if (!I_HRQ) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_state <= IDLE;
        end else if (I_CLK_EN) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (I_HRQ && w_armed) w_state_nxt = REQ;
            REQ: begin
                if (!I_HRQ) begin
                    w_state_nxt = WAITREL;
                end else if (!I_BUSAKn) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT:   if (w_release) w_state_nxt = TURN;
            TURN:    if (r_tcnt == '0) w_state_nxt = WAITREL;
            WAITREL: if (I_BUSAKn) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        w_busrq_n_nxt  = O_BUSRQn;
        w_hlda_nxt     = O_HLDA;
        w_bus_sel_nxt  = O_BUS_SEL;
        w_hold_cnt_nxt = O_HOLD_CNT;
        w_gcnt_nxt     = r_gcnt;
        w_tcnt_nxt     = r_tcnt;
        case (r_state)
            IDLE: begin
                if (I_HRQ && w_armed) w_busrq_n_nxt = 1'b0;
            end
            REQ: begin
                if (!I_HRQ) begin
                    w_busrq_n_nxt = 1'b1;
                end else if (!I_BUSAKn) begin
                    w_hlda_nxt    = 1'b1;
                    w_bus_sel_nxt = 1'b1;
                    w_gcnt_nxt    = '0;
                end
            end
            GRANT: begin
                w_gcnt_nxt = w_gcnt_inc;
                if (w_release) begin
                    w_hlda_nxt     = 1'b0;
                    w_hold_cnt_nxt = w_gcnt_inc;
                    w_tcnt_nxt     = TURN_CNT_W'(RELEASE_DLY);
                end
            end
            TURN: begin
                if (r_tcnt == '0) begin
                    w_bus_sel_nxt = 1'b0;
                    w_busrq_n_nxt = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt - TURN_CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            O_BUSRQn   <= 1'b1;
            O_HLDA     <= 1'b0;
            O_BUS_SEL  <= 1'b0;
            O_BUSY     <= 1'b0;
            O_HOLD_CNT <= '0;
            r_gcnt     <= '0;
            r_tcnt     <= '0;
        end else if (I_CLK_EN) begin
            O_BUSRQn   <= w_busrq_n_nxt;
            O_HLDA     <= w_hlda_nxt;
            O_BUS_SEL  <= w_bus_sel_nxt;
            O_BUSY     <= (w_state_nxt != IDLE);
            O_HOLD_CNT <= w_hold_cnt_nxt;
            r_gcnt     <= w_gcnt_nxt;
            r_tcnt     <= w_tcnt_nxt;
        end
    end

endmodule

// File: tb/tb_dkong_bus_hold.sv
// Self-checking bench for dkong_bus_hold; expected timing derived from the handshake rules.
module tb_dkong_bus_hold;

    localparam int RD = 2;
`ifdef DKONG_BUS_HOLD_WDOG_EN
    localparam int NORM_HOLD = 12;
    localparam int RAND_HOLD = 12;
`else
    localparam int NORM_HOLD = 1536;
    localparam int RAND_HOLD = 40;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        hrq;
    logic        busak_n;
    logic        busrq_n;
    logic        hlda;
    logic        bus_sel;
    logic        busy;
    logic [15:0] hold_cnt;
    logic        wdog;

    int checks = 0;
    int errors = 0;
    bit en_quarter = 1'b0;
    int dis_run = 0;

    dkong_bus_hold #(
        .RELEASE_DLY (RD),
        .WDOG_LIMIT  (16'd16)
    ) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_CLK_EN   (clk_en),
        .I_HRQ      (hrq),
        .I_BUSAKn   (busak_n),
        .O_BUSRQn   (busrq_n),
        .O_HLDA     (hlda),
        .O_BUS_SEL  (bus_sel),
        .O_BUSY     (busy),
        .O_HOLD_CNT (hold_cnt),
        .O_WDOG     (wdog)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout got still_running exp finished");
        $fatal(1, "bench timeout");
    end

    // One clock; in quarter mode the enable is random (~1/4) but never off for long.
    task automatic tick();
        if (en_quarter) clk_en = ($urandom_range(0, 3) == 0) || (dis_run >= 6);
        else            clk_en = 1'b1;
        if (clk_en) dis_run = 0;
        else        dis_run++;
        @(posedge clk);
        #1;
    endtask

    task automatic en_edge();
        tick();
        while (!clk_en) tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({busrq_n, hlda, bus_sel, busy, wdog} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", {busrq_n, hlda, bus_sel, busy, wdog}, 5'b10000);
        end
        checks++;
        if (hold_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", hold_cnt);
        end
        rst = 1'b0;
        repeat (2) en_edge();
        checks++;
        if ({busrq_n, busy} !== 2'b10) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp %b", {busrq_n, busy}, 2'b10);
        end
    endtask

    // Full request/grant/release transaction with expectations from the protocol latencies.
    task automatic test_grant(input string tag, input int ack_dly, input int hold);
        int exp_cnt;
        exp_cnt = (hold > 65535) ? 65535 : hold;
        hrq = 1'b1;
        tick();
        while (!clk_en) begin
            checks++;
            if (busrq_n !== 1'b1) begin
                errors++;
                $display("FAIL %s busrq_frozen got %b exp 1", tag, busrq_n);
            end
            tick();
        end
        checks++;
        if ({busrq_n, hlda, busy} !== 3'b001) begin
            errors++;
            $display("FAIL %s busrq_fall got %b exp %b", tag, {busrq_n, hlda, busy}, 3'b001);
        end
        repeat (ack_dly) begin
            en_edge();
            checks++;
            if ({busrq_n, hlda} !== 2'b00) begin
                errors++;
                $display("FAIL %s req_wait got %b exp %b", tag, {busrq_n, hlda}, 2'b00);
            end
        end
        busak_n = 1'b0;
        en_edge();
        checks++;
        if ({hlda, bus_sel, busy} !== 3'b111) begin
            errors++;
            $display("FAIL %s hlda_rise got %b exp %b", tag, {hlda, bus_sel, busy}, 3'b111);
        end
        repeat (hold - 1) en_edge();
        checks++;
        if (hlda !== 1'b1) begin
            errors++;
            $display("FAIL %s hlda_held got %b exp 1", tag, hlda);
        end
        hrq = 1'b0;
        en_edge();
        checks++;
        if ({hlda, bus_sel, busrq_n} !== 3'b010) begin
            errors++;
            $display("FAIL %s hlda_fall got %b exp %b", tag, {hlda, bus_sel, busrq_n}, 3'b010);
        end
        checks++;
        if (hold_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL %s hold_cnt got %0d exp %0d", tag, hold_cnt, exp_cnt);
        end
        repeat (RD) en_edge();
        checks++;
        if ({bus_sel, busrq_n} !== 2'b10) begin
            errors++;
            $display("FAIL %s turn_hold got %b exp %b", tag, {bus_sel, busrq_n}, 2'b10);
        end
        en_edge();
        checks++;
        if ({bus_sel, busrq_n, busy} !== 3'b011) begin
            errors++;
            $display("FAIL %s sel_fall got %b exp %b", tag, {bus_sel, busrq_n, busy}, 3'b011);
        end
        en_edge();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s waitrel_busy got %b exp 1", tag, busy);
        end
        busak_n = 1'b1;
        en_edge();
        checks++;
        if ({busy, busrq_n, hlda, bus_sel} !== 4'b0100) begin
            errors++;
            $display("FAIL %s back_idle got %b exp %b", tag, {busy, busrq_n, hlda, bus_sel}, 4'b0100);
        end
    endtask

    task automatic test_normal();
        test_grant("normal", 3, NORM_HOLD);
        test_grant("min_hold", 0, 1);
    endtask

    task automatic test_abort();
        hrq = 1'b1;
        en_edge();
        en_edge();
        checks++;
        if ({busrq_n, hlda} !== 2'b00) begin
            errors++;
            $display("FAIL abort_req got %b exp %b", {busrq_n, hlda}, 2'b00);
        end
        // CPU acks in the very cycle the DMA gives up: abort wins
        hrq = 1'b0;
        busak_n = 1'b0;
        en_edge();
        checks++;
        if ({hlda, bus_sel, busrq_n, busy} !== 4'b0011) begin
            errors++;
            $display("FAIL abort_prio got %b exp %b", {hlda, bus_sel, busrq_n, busy}, 4'b0011);
        end
        repeat (3) begin
            en_edge();
            checks++;
            if ({hlda, busy} !== 2'b01) begin
                errors++;
                $display("FAIL abort_waitrel got %b exp %b", {hlda, busy}, 2'b01);
            end
        end
        busak_n = 1'b1;
        en_edge();
        checks++;
        if ({busy, busrq_n} !== 2'b01) begin
            errors++;
            $display("FAIL abort_idle got %b exp %b", {busy, busrq_n}, 2'b01);
        end
        hrq = 1'b1;
        en_edge();
        hrq = 1'b0;
        en_edge();
        checks++;
        if ({busrq_n, busy, hlda} !== 3'b110) begin
            errors++;
            $display("FAIL abort_noack got %b exp %b", {busrq_n, busy, hlda}, 3'b110);
        end
        en_edge();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_noack_idle got %b exp 0", busy);
        end
    endtask

    task automatic test_clk_en();
        en_quarter = 1'b1;
        test_grant("ce_fixed", 2, 9);
        test_grant("ce_rand", int'($urandom_range(0, 4)), int'($urandom_range(1, RAND_HOLD)));
        en_quarter = 1'b0;
    endtask

    task automatic test_back_to_back();
        int a;
        int h;
        for (int i = 0; i < 4; i++) begin
            a = int'($urandom_range(0, 4));
            h = int'($urandom_range(1, RAND_HOLD));
            test_grant("b2b", a, h);
        end
    endtask

`ifdef DKONG_BUS_HOLD_WDOG_EN
    task automatic test_wdog();
        hrq = 1'b1;
        en_edge();
        busak_n = 1'b0;
        en_edge();
        repeat (15) en_edge();
        checks++;
        if ({hlda, wdog} !== 2'b10) begin
            errors++;
            $display("FAIL wdog_before got %b exp %b", {hlda, wdog}, 2'b10);
        end
        en_edge();
        checks++;
        if ({hlda, bus_sel, wdog} !== 3'b011) begin
            errors++;
            $display("FAIL wdog_fire got %b exp %b", {hlda, bus_sel, wdog}, 3'b011);
        end
        checks++;
        if (hold_cnt !== 16'd16) begin
            errors++;
            $display("FAIL wdog_cnt got %0d exp 16", hold_cnt);
        end
        repeat (RD + 1) en_edge();
        busak_n = 1'b1;
        en_edge();
        checks++;
        if ({busy, busrq_n, bus_sel} !== 3'b010) begin
            errors++;
            $display("FAIL wdog_idle got %b exp %b", {busy, busrq_n, bus_sel}, 3'b010);
        end
        repeat (10) begin
            en_edge();
            checks++;
            if (busrq_n !== 1'b1) begin
                errors++;
                $display("FAIL wdog_unarmed got %b exp 1", busrq_n);
            end
        end
        hrq = 1'b0;
        en_edge();
        hrq = 1'b1;
        en_edge();
        checks++;
        if (busrq_n !== 1'b0) begin
            errors++;
            $display("FAIL wdog_rearm got %b exp 0", busrq_n);
        end
        hrq = 1'b0;
        repeat (2) en_edge();
        checks++;
        if ({busy, wdog} !== 2'b01) begin
            errors++;
            $display("FAIL wdog_sticky got %b exp %b", {busy, wdog}, 2'b01);
        end
    endtask
`else
    task automatic test_no_wdog();
        hrq = 1'b1;
        en_edge();
        busak_n = 1'b0;
        en_edge();
        repeat (100) begin
            en_edge();
            checks++;
            if ({hlda, wdog} !== 2'b10) begin
                errors++;
                $display("FAIL nowdog_hold got %b exp %b", {hlda, wdog}, 2'b10);
            end
        end
        hrq = 1'b0;
        repeat (RD + 2) en_edge();
        busak_n = 1'b1;
        en_edge();
        checks++;
        if (hold_cnt !== 16'd101) begin
            errors++;
            $display("FAIL nowdog_cnt got %0d exp 101", hold_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nowdog_idle got %b exp 0", busy);
        end
    endtask
`endif

    task automatic test_reset_mid_grant();
        hrq = 1'b1;
        en_edge();
        busak_n = 1'b0;
        repeat (6) en_edge();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({hlda, bus_sel, busy, busrq_n, wdog} !== 5'b00010) begin
            errors++;
            $display("FAIL rst_async got %b exp %b", {hlda, bus_sel, busy, busrq_n, wdog}, 5'b00010);
        end
        checks++;
        if (hold_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_async_cnt got %0d exp 0", hold_cnt);
        end
        hrq = 1'b0;
        busak_n = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (2) en_edge();
        checks++;
        if ({busy, busrq_n, hlda} !== 3'b010) begin
            errors++;
            $display("FAIL rst_release got %b exp %b", {busy, busrq_n, hlda}, 3'b010);
        end
    endtask

    initial begin
        rst = 1'b1;
        clk_en = 1'b0;
        hrq = 1'b0;
        busak_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_normal();
        test_abort();
        test_clk_en();
        test_back_to_back();
`ifdef DKONG_BUS_HOLD_WDOG_EN
        test_wdog();
`else
        test_no_wdog();
`endif
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
